// File: rtl/instr_encoder.sv
// Encodes DP/memory/branch field bundles into 32-bit ARM words and streams
// them out with a sequential word address through a one-entry output register.
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [3:0]        cond,
    input  logic [3:0]        cmd,
    input  logic              s,
    input  logic              i,
    input  logic              l,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [3:0]        rm,
    input  logic [23:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    logic [31:0] word;
    logic        rej;
    logic        s_eff;
    logic        accept;
    logic        xfer;

    // Compare/test opcodes only make sense with flags set, so S is forced.
    assign s_eff = s | (cmd[3:2] == 2'b10);

    always_comb begin
        word = 32'h0;
        rej  = 1'b0;
        case (op_e'(op))
            OP_DP: begin
                word = {cond, 2'b00, i, cmd, s_eff, rn, rd,
                        i ? {4'h0, imm[7:0]} : {8'h00, rm}};
                rej  = i & (imm[23:8] != 16'h0);
            end
            OP_MEM: word = {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, l, rn, rd, imm[11:0]};
            OP_BR:  word = {cond, 3'b101, 1'b0, imm};
            default: rej = 1'b1;
        endcase
    end

    assign in_ready = flush | ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign xfer     = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_addr  <= BASE;
            err       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_addr  <= BASE;
            err       <= 1'b0;
        end else begin
            if (xfer)
                out_addr <= out_addr + 1'b1;
            if (accept && !rej) begin
                out_valid <= 1'b1;
                out_instr <= word;
            end else begin
                // A rejected bundle still consumes its handshake but never fills the slot.
                if (accept)
                    err <= 1'b1;
                if (xfer)
                    out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, rejection, flush, reset,
// and a back-pressured 66-word stream that wraps the 6-bit address.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [3:0]  cond, cmd, rn, rd, rm;
    logic        s, i, l;
    logic [23:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [5:0]  out_addr;
    logic        err;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .cond(cond), .cmd(cmd), .s(s), .i(i), .l(l),
        .rn(rn), .rd(rd), .rm(rm), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [3:0] c, input logic [3:0] cm,
                         input logic ss, input logic ii, input logic ll,
                         input logic [3:0] n, input logic [3:0] d, input logic [3:0] m,
                         input logic [23:0] im);
        op = o; cond = c; cmd = cm; s = ss; i = ii; l = ll;
        rn = n; rd = d; rm = m; imm = im;
    endtask

    // Accept one bundle with out_ready high; check it one cycle later, then check it retired.
    task automatic send_one(input string tag, input logic [31:0] exp_w, input logic [5:0] exp_a);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'h1);
        chk({tag, "_instr"}, out_instr, exp_w);
        chk({tag, "_addr"}, 32'(out_addr), 32'(exp_a));
        @(negedge clk);
        chk({tag, "_retired"}, 32'(out_valid), 32'h0);
    endtask

    function automatic logic [31:0] stream_word(input int r);
        return {4'hE, 4'b1010, 24'h000100 + 24'(r)};
    endfunction

    initial begin
        int k, r;
        bit stalled;
        logic [31:0] p_instr;
        logic [5:0]  p_addr;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(2'b00, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 24'h0);
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_addr", 32'(out_addr), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'h1);

        drive(2'b00, 4'hE, 4'h4, 0, 1, 0, 4'h1, 4'h2, 4'h0, 24'h000005);
        send_one("dp_imm", 32'hE2812005, 6'd0);
        drive(2'b00, 4'hE, 4'hA, 0, 0, 0, 4'h1, 4'h0, 4'h2, 24'h0);
        send_one("cmp", 32'hE1510002, 6'd1);
        drive(2'b01, 4'hE, 4'h0, 0, 0, 1, 4'h0, 4'h3, 4'h0, 24'h000010);
        send_one("ldr", 32'hE5903010, 6'd2);
        drive(2'b01, 4'hE, 4'h0, 0, 0, 0, 4'h0, 4'h3, 4'h0, 24'h000010);
        send_one("str", 32'hE5803010, 6'd3);
        drive(2'b10, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 24'hFFFFFE);
        send_one("branch", 32'h0AFFFFFE, 6'd4);

        // Rejections: no output word, address stays, err sticks.
        drive(2'b11, 4'hE, 4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 24'h0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill_err", 32'(err), 32'h1);
        chk("ill_valid", 32'(out_valid), 32'h0);
        chk("ill_addr", 32'(out_addr), 32'd5);
        drive(2'b00, 4'hE, 4'h4, 0, 1, 0, 4'h1, 4'h2, 4'h0, 24'h000100);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bigimm_err", 32'(err), 32'h1);
        chk("bigimm_valid", 32'(out_valid), 32'h0);
        chk("bigimm_addr", 32'(out_addr), 32'd5);

        // Flush wins over a valid bundle in the same cycle.
        drive(2'b00, 4'hE, 4'h4, 0, 1, 0, 4'h1, 4'h2, 4'h0, 24'h000005);
        flush = 1'b1; in_valid = 1'b1;
        #1 chk("flush_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_err", 32'(err), 32'h0);
        chk("flush_addr", 32'(out_addr), 32'h0);
        chk("flush_valid", 32'(out_valid), 32'h0);

        // 66-word stream, out_ready low 3 cycles then high 1.
        k = 0; r = 0; stalled = 0; p_instr = 32'h0; p_addr = 6'h0;
        for (int cyc = 0; cyc < 2000 && r < 66; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 4 == 3);
            if (k < 66) begin
                drive(2'b10, 4'hE, 4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 24'h000100 + 24'(k));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                chk("stall_instr", out_instr, p_instr);
                chk("stall_addr", 32'(out_addr), 32'(p_addr));
            end
            if (out_valid) begin
                chk("strm_instr", out_instr, stream_word(r));
                chk("strm_addr", 32'(out_addr), 32'(r % 64));
                if (out_ready) begin
                    r++;
                    stalled = 0;
                end else begin
                    chk("stall_ready", 32'(in_ready), 32'h0);
                    stalled = 1;
                    p_instr = out_instr;
                    p_addr  = out_addr;
                end
            end else begin
                stalled = 0;
            end
            if (in_valid && in_ready) k++;
        end
        in_valid = 1'b0;
        chk("strm_count", 32'(r), 32'd66);
        @(negedge clk);
        chk("strm_end_addr", 32'(out_addr), 32'd2);
        chk("strm_end_valid", 32'(out_valid), 32'h0);

        // Reset while a word is held drops it at once.
        out_ready = 1'b0;
        drive(2'b10, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 24'h000001);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_addr", 32'(out_addr), 32'h0);
        chk("async_rst_instr", out_instr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Assembles instruction-field bundles into 32-bit ARM machine words and emits them, with a sequential word address, as an instruction-memory write stream.
- It is the inverse of the control decoder: it encodes exactly the subset the decoder handles: DP imm/reg, LDR/STR with immediate offset, and B.
- It sits between the boot/program loader and instruction memory.
- It uses a one-entry registered pipeline with valid/ready handshakes on both sides.

## Interface
Parameters:
- ADDR_W, 6, width of word address, counter range 0..2^ADDR_W-1
- BASE_ADDR, 0, first address emitted after reset or flush

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous and active-low
- flush  input  1  synchronous clear: drops held word, address back to BASE_ADDR, clears err
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle this cycle
- op  input  2  00 DP, 01 memory, 10 branch, 11 illegal
- cond  input  4  condition field, copied to bits 31:28
- cmd  input  4  DP opcode
- s  input  1  DP set-flags
- i  input  1  DP immediate select (1 = imm8, 0 = register rm)
- l  input  1  memory: 1 LDR, 0 STR
- rn, rd, rm  input  4 each  register numbers
- imm  input  24  DP uses [7:0], memory uses [11:0], branch uses [23:0]
- out_valid  output  1  encoded word valid
- out_ready  input  1  instruction memory accepts word
- out_instr  output  32  encoded word
- out_addr  output  ADDR_W  word address of out_instr
- err  output  1  sticky: at least one bundle was rejected

## Operation
Encoding is combinational from the inputs and registered on acceptance.
- DP: {cond, 2'b00, i, cmd, s', rn, rd, i ? {4'h0, imm[7:0]} : {8'h00, rm}}.
  - Rotate and shift are always 0.
  - s' = 1 when cmd is 8/9/A/B (TST/TEQ/CMP/CMN); otherwise s' = s.
- Memory: {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, l, rn, rd, imm[11:0]}.
  - Fixed fields: I-bar=0, P=1, U=1, B=0, W=0.
- Branch: {cond, 3'b101, 1'b0, imm[23:0]}. The link bit is always 0.

Rejection:
- A bundle is rejected when op=11, or when op=00 with i=1 and imm[23:8] != 0.
- A rejected bundle completes its input handshake but produces no output word.
- Rejection sets err, and out_addr does not advance.

Address and flush:
- The address counter advances by 1 on each output transfer (out_valid & out_ready).
- The counter wraps from 2^ADDR_W-1 to 0 silently.
- flush has priority over any handshake in the same cycle. The bundle presented in a flush cycle is discarded.

## Timing
- Reset (asynchronous assert, clk-synchronous release) sets:
  - out_valid=0
  - out_instr=32'h0
  - out_addr=BASE_ADDR
  - err=0
- in_ready = !out_valid | out_ready. It is combinational from the output register state and out_ready. It is forced 1 during flush.
- Acceptance: in_valid & in_ready at an edge latches the encoded word. out_valid is high the next cycle, giving a latency of 1.
- Throughput: with out_ready held 1, one word per cycle.
- Back-pressure: while out_valid & !out_ready, out_instr and out_addr hold stable and in_ready=0.
- Simultaneous output transfer and new acceptance:
  - out_instr loads the new word.
  - out_addr increments.
  - out_valid stays 1.
- Output transfer with no new acceptance: out_valid falls to 0 and out_addr increments.
- Rejected bundle on a cycle with an output transfer: the current word retires normally and out_valid falls to 0.
- err rises the cycle after the rejected acceptance. It clears only on reset or flush.
- Reset asserted mid-stream discards the held word immediately, with no output transfer.

## Test plan
- DP immediate: cond=E, cmd=4, s=0, i=1, rn=1, rd=2, imm=5 -> out_instr=0xE2812005 at out_addr=0, one cycle after acceptance.
- Compare forcing S: cond=E, cmd=A, s=0, i=0, rn=1, rd=0, rm=2 -> 0xE1510002.
- Memory:
  - LDR cond=E, l=1, rn=0, rd=3, imm=0x010 -> 0xE5903010.
  - STR with the same fields and l=0 -> 0xE5803010.
- Branch: cond=0, imm=0xFFFFFE -> 0x0AFFFFFE.
- Back-pressure and wrap:
  - Send 66 back-to-back words with out_ready toggled 3 low / 1 high.
  - out_instr and out_addr are stable while stalled.
  - No word is lost or duplicated.
  - Addresses run 0..63 then 0,1.
- Error, flush and reset:
  - op=11 -> err=1 next cycle, no out_valid, out_addr unchanged.
  - DP i=1 imm=0x100 -> rejected the same way.
  - flush -> err=0, out_addr=0.
  - reset asserted with out_valid=1 -> out_valid=0 immediately.
